// File: rtl/mfp_pkg.sv
// Shared MFixPoint helpers: width math and the round-half-up / symmetric-saturate step.
package mfp_pkg;

  // Wide enough for any sum tree this family builds; the round step runs at this width.
  localparam int MAXW = 128;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } rsat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision adder-tree width for arrl products of two inaw-bit operands.
  function automatic int sum_width(input int inaw, input int arrl);
    return 2 * inaw + clog2(arrl);
  endfunction

  // Fractional bits dropped going from Q.(2*inaw-2) to Q.(accw-1).
  function automatic int round_shift(input int inaw, input int accw);
    return (2 * inaw - 2) - (accw - 1);
  endfunction

  // Round half toward +inf, then clamp to +/-(2^(outw-1)-1); -2^(outw-1) also counts as a clamp.
  function automatic rsat_t round_sat(input logic signed [MAXW-1:0] sum, input int sh,
                                      input int outw);
    logic signed [MAXW-1:0] one, r, maxv;
    rsat_t res;
    one = MAXW'(1);
    r   = sum;
    if (sh > 0) r = (sum + (one <<< (sh - 1))) >>> sh;
    maxv    = (one <<< (outw - 1)) - one;
    res.sat = 1'b0;
    res.val = 64'(r);
    if (r > maxv) begin
      res.sat = 1'b1;
      res.val = 64'(maxv);
    end else if (r < -maxv) begin
      res.sat = 1'b1;
      res.val = 64'(-maxv);
    end
    return res;
  endfunction

endpackage

// File: rtl/mfp_adder_tree.sv
// Recursive signed reduction of N W-bit elements into a W+clog2(N)-bit sum, never wraps.
module mfp_adder_tree
  import mfp_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0][W-1:0]          din,
  output logic signed [W+clog2(N)-1:0] sum
);

  localparam int OW = W + clog2(N);

  if (N == 1) begin : g_leaf
    assign sum = $signed(din[0]);
  end else begin : g_node
    // Left half takes the odd element so its width bound stays clog2(N)-1.
    localparam int NL = (N + 1) / 2;
    localparam int NR = N - NL;

    logic signed [W+clog2(NL)-1:0] sl;
    logic signed [W+clog2(NR)-1:0] sr;

    mfp_adder_tree #(.N(NL), .W(W)) u_l (.din(din[NL-1:0]), .sum(sl));
    mfp_adder_tree #(.N(NR), .W(W)) u_r (.din(din[N-1:NL]), .sum(sr));

    assign sum = OW'(sl) + OW'(sr);
  end

endmodule

// File: rtl/mfp_mac_parallel.sv
// Two-stage parallel dot product: registered products, then adder tree + round/saturate.
module mfp_mac_parallel
  import mfp_pkg::*;
#(
  parameter int InAW       = 18,
  parameter int ArrL       = 40,
  parameter int AccW_ROUND = 18
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [InAW*ArrL-1:0]         dA_arr,
  input  logic [InAW*ArrL-1:0]         dB_arr,
  output logic                         sat_flag,
  output logic signed [AccW_ROUND-1:0] acc_sum_rounded
);

  localparam int PW   = 2 * InAW;
  localparam int SUMW = sum_width(InAW, ArrL);
  localparam int SH   = round_shift(InAW, AccW_ROUND);

  logic [ArrL-1:0][PW-1:0] prod_d, prod_q;
  logic signed [SUMW-1:0]  tree_sum;
  rsat_t                   rs;

  for (genvar i = 0; i < ArrL; i++) begin : g_mul
    logic signed [InAW-1:0] a, b;
    assign a         = dA_arr[i*InAW +: InAW];
    assign b         = dB_arr[i*InAW +: InAW];
    assign prod_d[i] = PW'(a) * PW'(b);
  end

  always_ff @(posedge clk) begin
    if (clr) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  mfp_adder_tree #(.N(ArrL), .W(PW)) u_tree (
    .din (prod_q),
    .sum (tree_sum)
  );

  always_comb rs = round_sat(MAXW'(tree_sum), SH, AccW_ROUND);

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_sum_rounded <= '0;
      sat_flag        <= 1'b0;
    end else begin
      acc_sum_rounded <= AccW_ROUND'(rs.val);
      sat_flag        <= rs.sat;
    end
  end

endmodule

// File: tb/tb_mfp_mac_parallel.sv
// Directed checks for mfp_mac_parallel: reset, latency, rounding, saturation, streaming Gaussian filter.
module tb_mfp_mac_parallel;

  localparam int InAW = 18;
  localparam int ArrL = 40;
  localparam int AccW = 18;
  localparam int NV   = 30;

  logic                   clk = 1'b0;
  logic                   clr;
  logic [InAW*ArrL-1:0]   da, db;
  logic                   sat_flag;
  logic signed [AccW-1:0] acc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mfp_mac_parallel #(.InAW(InAW), .ArrL(ArrL), .AccW_ROUND(AccW)) dut (
    .clk             (clk),
    .clr             (clr),
    .dA_arr          (da),
    .dB_arr          (db),
    .sat_flag        (sat_flag),
    .acc_sum_rounded (acc)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_vec();
    da = '0;
    db = '0;
  endtask

  task automatic set_a(input int i, input longint v);
    da[i*InAW +: InAW] = InAW'(v);
  endtask

  task automatic set_b(input int i, input longint v);
    db[i*InAW +: InAW] = InAW'(v);
  endtask

  // Called at a negedge right after inputs are set; result is visible two negedges later.
  task automatic run_vec(input string tag, input longint exp, input longint exps);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_val"}, acc, exp);
    chk({tag, "_sat"}, sat_flag, exps);
  endtask

  longint xs[0:127];
  longint gb[0:ArrL-1];
  longint exp_q[$];
  real    expr_q[$];

  initial begin
    clr = 1'b1;
    for (int i = 0; i < ArrL; i++) begin
      set_a(i, 65536);
      set_b(i, 65536);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("reset_val", acc, 0);
    chk("reset_sat", sat_flag, 0);

    // Release with stable single-term input: nothing valid after 1 cycle, result after 2.
    clear_vec();
    set_a(0, 65536);
    set_b(0, 65536);
    clr = 1'b0;
    @(negedge clk);
    chk("lat1_val", acc, 0);
    @(negedge clk);
    chk("lat2_val", acc, 32768);
    chk("lat2_sat", sat_flag, 0);

    clear_vec(); set_a(0, 1);  set_b(0, 65536); run_vec("rnd_p_half", 1, 0);
    clear_vec(); set_a(0, -1); set_b(0, 65536); run_vec("rnd_n_half", 0, 0);
    clear_vec(); set_a(0, 3);  set_b(0, 32768); run_vec("rnd_p_3q", 1, 0);

    clear_vec();
    for (int i = 0; i < ArrL; i++) begin set_a(i, 131071); set_b(i, 131071); end
    run_vec("sat_pos", 131071, 1);

    clear_vec();
    for (int i = 0; i < ArrL; i++) begin set_a(i, 131071); set_b(i, -131071); end
    run_vec("sat_neg", -131071, 1);

    // (-1)*(-1) = +1 exceeds MAX.
    clear_vec(); set_a(0, -131072); set_b(0, -131072); run_vec("neg1sq", 131071, 1);

    // Sum of exactly -1.0 rounds to -2^17, which clamps.
    clear_vec();
    set_a(0, -131072); set_b(0, 131071);
    set_a(1, -131072); set_b(1, 1);
    run_vec("min_code", -131071, 1);

    clear_vec();
    for (int i = 0; i < ArrL; i++) begin
      set_a(i, (i % 2 == 0) ? 131071 : -131071);
      set_b(i, 3277);
    end
    run_vec("mixed", 0, 0);

    // Mid-flight reset discards the saturating vector already in the product stage.
    clear_vec();
    for (int i = 0; i < ArrL; i++) begin set_a(i, 131071); set_b(i, 131071); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("midrst_val0", acc, 0);
    chk("midrst_sat0", sat_flag, 0);
    @(negedge clk);
    chk("midrst_val1", acc, 0);
    @(negedge clk);
    chk("midrst_val2", acc, 131071);
    chk("midrst_sat2", sat_flag, 1);

    // Streaming window against a Gaussian table (sigma 2, centre 20).
    for (int k = 0; k < 128; k++) xs[k] = ((longint'(k) * 12345 + 678) % 32768) - 16384;
    for (int i = 0; i < ArrL; i++) begin
      real d;
      d     = real'(i - 20);
      gb[i] = longint'($rtoi(131071.0 * $exp(-(d * d) / 8.0) + 0.5));
    end
    clear_vec();
    for (int i = 0; i < ArrL; i++) set_b(i, gb[i]);
    for (int j = 0; j < NV + 2; j++) begin
      if (j >= 2) begin
        longint e;
        real    er, diff;
        e    = exp_q.pop_front();
        er   = expr_q.pop_front();
        diff = $itor(acc) - er;
        chk("stream_exact", acc, e);
        chk("stream_sat", sat_flag, 0);
        chk("stream_real", (diff <= 1.0 && diff >= -1.0) ? 1 : 0, 1);
      end
      if (j < NV) begin
        longint s, r;
        real    sr;
        s  = 0;
        sr = 0.0;
        for (int i = 0; i < ArrL; i++) begin
          set_a(i, xs[j+i]);
          s  += xs[j+i] * gb[i];
          sr += ($itor(xs[j+i]) / 131072.0) * ($itor(gb[i]) / 131072.0);
        end
        r = (s + 65536) >>> 17;
        if (r > 131071) r = 131071;
        else if (r < -131071) r = -131071;
        exp_q.push_back(r);
        expr_q.push_back(sr * 131072.0);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
